// File: rtl/adder_tree_acc_pkg.sv
// Shared helpers for tree-based neuron blocks: width arithmetic, beat tags, FSM states.
// Latency: none (types and constant functions only).
// Backpressure: none.
package adder_tree_acc_pkg;

  // Frame accumulator states.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Beat qualifier travelling alongside the tree data.
  typedef struct packed {
    logic vld;
    logic lst;
  } tag_t;

  // Number of registered tree levels; a single lane still gets one register.
  function automatic int tree_lvls(input int p);
    return (p <= 1) ? 1 : $clog2(p);
  endfunction

  // Element width at tree level k (full growth, one bit per level).
  function automatic int lvl_w(input int d, input int k);
    return d + k;
  endfunction

  // Element count at tree level k: ceil(p / 2^k).
  function automatic int lvl_n(input int p, input int k);
    return (p + (1 << k) - 1) >> k;
  endfunction

  // Full-precision frame accumulator width.
  function automatic int acc_w(input int d, input int p, input int a);
    return d + $clog2(p) + $clog2(a);
  endfunction

  // Beat counter width, able to hold the value a.
  function automatic int cnt_w(input int a);
    return $clog2(a + 1);
  endfunction

  // Bit offset of level k inside the flattened tree bus.
  function automatic int bus_off(input int p, input int d, input int k);
    int o;
    o = 0;
    for (int j = 0; j < k; j++) begin
      o += lvl_n(p, j) * lvl_w(d, j);
    end
    return o;
  endfunction

endpackage

// File: rtl/adder_tree_acc_tree_level.sv
// One reduction level: N signed lanes in, ceil(N/2) lanes out, one bit wider.
// Latency: 1 cycle, data and tag registered together.
// Backpressure: none, accepts a beat every cycle.
module adder_tree_acc_tree_level
  import adder_tree_acc_pkg::*;
#(
  parameter int N = 5,
  parameter int W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N*W-1:0]               d_dat,
  input  tag_t                         d_tag,
  output logic [((N+1)/2)*(W+1)-1:0]   q_dat,
  output tag_t                         q_tag
);

  localparam int NO = (N + 1) / 2;

  logic [NO*(W+1)-1:0] sum;

  for (genvar i = 0; i < NO; i++) begin : g_pair
    logic [W-1:0] a;
    assign a = d_dat[2*i*W +: W];
    if (2*i + 1 < N) begin : g_add
      logic [W-1:0] b;
      assign b = d_dat[(2*i+1)*W +: W];
      assign sum[i*(W+1) +: W+1] = {a[W-1], a} + {b[W-1], b};
    end else begin : g_pass
      // Odd leftover lane is only sign-extended to keep widths uniform.
      assign sum[i*(W+1) +: W+1] = {a[W-1], a};
    end
  end

  // Data register, no reset needed: it is qualified by the tag.
  always_ff @(posedge clk) begin
    q_dat <= sum;
  end

  // Tag register; last only counts when it rides on a valid beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_tag <= '0;
    end else begin
      q_tag.vld <= d_tag.vld;
      q_tag.lst <= d_tag.lst & d_tag.vld;
    end
  end

endmodule

// File: rtl/adder_tree_acc.sv
// Signed lane sum per beat via registered tree, accumulated into one frame sum (ADDER_TREE_ACC_SAT_EN: saturate).
// Latency: last beat at din to dout_valid = L+1 cycles, L = tree levels (1 when PARALLEL=1).
// Backpressure: none; 1 beat/cycle, frames back-to-back, consumer must take every dout_valid pulse.
module adder_tree_acc
  import adder_tree_acc_pkg::*;
#(
  parameter int DIN_WIDTH  = 8,
  parameter int PARALLEL   = 5,
  parameter int ACC_LEN    = 16,
  parameter int DOUT_WIDTH = acc_w(DIN_WIDTH, PARALLEL, ACC_LEN)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIN_WIDTH*PARALLEL-1:0] din,
  input  logic                          din_valid,
  input  logic                          din_last,
  output logic [DOUT_WIDTH-1:0]         dout,
  output logic                          dout_valid,
  output logic                          dout_ovf
);

  localparam int L     = tree_lvls(PARALLEL);
  localparam int ACC_W = acc_w(DIN_WIDTH, PARALLEL, ACC_LEN);
  localparam int CNT_W = cnt_w(ACC_LEN);
  localparam int TW    = DIN_WIDTH + L;
  localparam int BUS_W = bus_off(PARALLEL, DIN_WIDTH, L + 1);

  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(ACC_LEN);

  // All tree levels packed back to back; level 0 is the raw input.
  logic [BUS_W-1:0] lvl_bus;
  tag_t             lvl_tag [0:L];

  assign lvl_bus[DIN_WIDTH*PARALLEL-1:0] = din;
  assign lvl_tag[0] = {din_valid, din_last};

  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int NI = lvl_n(PARALLEL, k);
    localparam int NO = lvl_n(PARALLEL, k + 1);
    localparam int WI = lvl_w(DIN_WIDTH, k);
    localparam int OI = bus_off(PARALLEL, DIN_WIDTH, k);
    localparam int OO = bus_off(PARALLEL, DIN_WIDTH, k + 1);

    adder_tree_acc_tree_level #(
      .N (NI),
      .W (WI)
    ) u_lvl (
      .clk   (clk),
      .rst_n (rst_n),
      .d_dat (lvl_bus[OI +: NI*WI]),
      .d_tag (lvl_tag[k]),
      .q_dat (lvl_bus[OO +: NO*(WI+1)]),
      .q_tag (lvl_tag[k+1])
    );
  end

  // Tree output beat.
  logic signed [TW-1:0]    t_sum;
  tag_t                    t_tag;
  logic signed [ACC_W-1:0] t_ext;

  assign t_sum = lvl_bus[BUS_W-1 -: TW];
  assign t_tag = lvl_tag[L];
  // The tree value always fits ACC_W, so narrowing here never loses information.
  assign t_ext = ACC_W'(t_sum);

  // Accumulator state.
  state_t                  state, state_n;
  logic signed [ACC_W-1:0] acc, acc_n;
  logic [CNT_W-1:0]        beat_cnt, cnt_n;
  logic [DOUT_WIDTH-1:0]   dout_n;
  logic                    dout_valid_n, dout_ovf_n;

  // Running sum and count including the current beat.
  logic signed [ACC_W-1:0] sum_nxt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic                    close;

  assign sum_nxt = (state == IDLE) ? t_ext : acc + t_ext;
  assign cnt_nxt = (state == IDLE) ? ONE_C : beat_cnt + ONE_C;
  assign close   = t_tag.vld && (t_tag.lst || (cnt_nxt == LEN_C));

  // Output formatting of the closing sum.
  logic [DOUT_WIDTH-1:0] fmt_dat;
  logic                  fmt_ovf;

  if (DOUT_WIDTH >= ACC_W) begin : g_wide
    assign fmt_dat = DOUT_WIDTH'(sum_nxt);
    assign fmt_ovf = 1'b0;
  end else begin : g_narrow
    localparam logic [DOUT_WIDTH-1:0] MAX_C = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic [DOUT_WIDTH-1:0] MIN_C = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
    // Fits iff every bit from the output sign bit upward is a copy of the sign.
    logic [ACC_W-DOUT_WIDTH:0] hi;
    assign hi      = sum_nxt[ACC_W-1:DOUT_WIDTH-1];
    assign fmt_ovf = !((&hi) || !(|hi));
`ifdef ADDER_TREE_ACC_SAT_EN
    assign fmt_dat = fmt_ovf ? (sum_nxt[ACC_W-1] ? MIN_C : MAX_C)
                             : sum_nxt[DOUT_WIDTH-1:0];
`else
    assign fmt_dat = sum_nxt[DOUT_WIDTH-1:0];
`endif
  end

  // Next-state: start, extend or close a frame on each valid tree beat.
  always_comb begin
    state_n      = state;
    acc_n        = acc;
    cnt_n        = beat_cnt;
    dout_n       = dout;
    dout_valid_n = 1'b0;
    dout_ovf_n   = dout_ovf;
    if (t_tag.vld) begin
      acc_n = sum_nxt;
      if (close) begin
        state_n      = IDLE;
        cnt_n        = '0;
        dout_n       = fmt_dat;
        dout_valid_n = 1'b1;
        dout_ovf_n   = fmt_ovf;
      end else begin
        state_n = ACCUM;
        cnt_n   = cnt_nxt;
      end
    end
  end

  // State and output registers; reset drops any partial frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      beat_cnt   <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_ovf   <= 1'b0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      beat_cnt   <= cnt_n;
      dout       <= dout_n;
      dout_valid <= dout_valid_n;
      dout_ovf   <= dout_ovf_n;
    end
  end

endmodule
